// File: rtl/reg_sel_pkg.sv
// Shared types and helpers for the register write-select sequencer.
// The stall feature is controlled by the REG_SEL_STALL_EN macro, which is used in reg_sel_sequencer.sv.
package reg_sel_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // The helper works at this maximum width. Callers truncate the result to their own register count.
    localparam int MAX_ADDR_W = 8;
    localparam int MAX_REGS   = 2 ** MAX_ADDR_W;

    function automatic logic [MAX_REGS-1:0] bin_to_onehot(input logic [MAX_ADDR_W-1:0] idx);
        logic [MAX_REGS-1:0] vec;
        vec      = '0;
        vec[idx] = 1'b1;
        return vec;
    endfunction

endpackage

// File: rtl/bin_onehot_decoder.sv
// Combinational binary-to-one-hot decoder.
// Its output feeds the registered write-enable bus.
module bin_onehot_decoder
    import reg_sel_pkg::*;
#(
    parameter int ADDR_W = 3
) (
    input  logic [ADDR_W-1:0]      addr,
    output logic [2**ADDR_W-1:0]   onehot
);

    localparam int OUT_W = 2 ** ADDR_W;

    assign onehot = OUT_W'(bin_to_onehot(MAX_ADDR_W'(addr)));

endmodule

// File: rtl/reg_sel_sequencer.sv
// Drives one registered one-hot write enable per cycle across consecutive registers, wrapping modulo NUM_REGS.
// Defining REG_SEL_STALL_EN adds a stall input that pauses a burst in progress.
module reg_sel_sequencer
    import reg_sel_pkg::*;
#(
    parameter int ADDR_W   = 3,
    parameter int NUM_REGS = 2 ** ADDR_W
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [ADDR_W-1:0]   base_addr,
    input  logic [ADDR_W:0]     count,
`ifdef REG_SEL_STALL_EN
    input  logic                stall,
`endif
    output logic [NUM_REGS-1:0] r_sig,
    output logic [ADDR_W-1:0]   cur_addr,
    output logic                busy,
    output logic                done
);

    localparam logic [ADDR_W:0]   NUM_REGS_C = (ADDR_W + 1)'(NUM_REGS);
    localparam logic [ADDR_W:0]   REMAIN_ONE = (ADDR_W + 1)'(1);
    localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(NUM_REGS - 1);
    localparam logic [ADDR_W-1:0] ADDR_ONE   = ADDR_W'(1);

    state_t                state_reg, state_next;
    logic [ADDR_W-1:0]     addr_reg, addr_next;
    logic [ADDR_W:0]       remain_reg, remain_next;
    logic [NUM_REGS-1:0]   r_sig_reg, r_sig_next;
    logic [ADDR_W-1:0]     cur_addr_reg, cur_addr_next;
    logic                  busy_reg, busy_next;
    logic                  done_reg, done_next;
    logic                  stall_active;
    logic [2**ADDR_W-1:0]  addr_onehot;

`ifdef REG_SEL_STALL_EN
    assign stall_active = stall;
`else
    assign stall_active = 1'b0;
`endif

    bin_onehot_decoder #(
        .ADDR_W (ADDR_W)
    ) u_decoder (
        .addr   (addr_reg),
        .onehot (addr_onehot)
    );

    // Outputs are computed from the current state and registered, so each beat lags the FSM by one cycle.
    always_comb begin
        state_next    = state_reg;
        addr_next     = addr_reg;
        remain_next   = remain_reg;
        r_sig_next    = '0;
        cur_addr_next = '0;
        busy_next     = 1'b0;
        done_next     = 1'b0;

        case (state_reg)
            IDLE: begin
                if (start) begin
                    if (count == '0) begin
                        done_next = 1'b1;
                    end else begin
                        addr_next   = base_addr;
                        remain_next = (count > NUM_REGS_C) ? NUM_REGS_C : count;
                        state_next  = RUN;
                    end
                end
            end
            RUN: begin
                busy_next = 1'b1;
                if (!stall_active) begin
                    r_sig_next    = addr_onehot[NUM_REGS-1:0];
                    cur_addr_next = addr_reg;
                    addr_next     = (addr_reg == LAST_ADDR) ? '0 : addr_reg + ADDR_ONE;
                    remain_next   = remain_reg - REMAIN_ONE;
                    if (remain_reg == REMAIN_ONE) begin
                        done_next  = 1'b1;
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            addr_reg     <= '0;
            remain_reg   <= '0;
            r_sig_reg    <= '0;
            cur_addr_reg <= '0;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
        end else begin
            state_reg    <= state_next;
            addr_reg     <= addr_next;
            remain_reg   <= remain_next;
            r_sig_reg    <= r_sig_next;
            cur_addr_reg <= cur_addr_next;
            busy_reg     <= busy_next;
            done_reg     <= done_next;
        end
    end

    assign r_sig    = r_sig_reg;
    assign cur_addr = cur_addr_reg;
    assign busy     = busy_reg;
    assign done     = done_reg;

endmodule
